mem_port_arbiter: RTL and testbench

- Shares the single unified LC-3b memory port between instruction fetch and the MEM stage of the pipeline.
- Fetch presents a PC and consumes `imem_r` and the returned instruction.
- MEM stage presents loads and stores and consumes `dmem_r`, `mem_stall` and read data.
- One transaction is in flight at a time against a handshaked, variable-latency memory (`mem_ready`).

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arb_streak.sv | 37 +++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified LC-3b memory port arbiter: state encodings, byte-enable codes, widths.
package mem_port_arbiter_pkg;

  localparam int LC3B_ADDR_W = 16;
  localparam int LC3B_WORD_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_IFETCH = 2'b01,
    ARB_DACC   = 2'b10
  } arb_state_e;

  localparam logic [1:0] WMASK_NONE = 2'b00;
  localparam logic [1:0] WMASK_LO   = 2'b01;
  localparam logic [1:0] WMASK_HI   = 2'b10;
  localparam logic [1:0] WMASK_WORD = 2'b11;

  // Byte enables {hi, lo} for a data access; reads never enable a lane.
  function automatic logic [1:0] wmask_f(input logic we, input logic byte_acc, input logic a0);
    logic [1:0] m;
    m = WMASK_NONE;
    if (we) m = byte_acc ? (a0 ? WMASK_HI : WMASK_LO) : WMASK_WORD;
    return m;
  endfunction

endpackage

// File: rtl/mem_port_arb_streak.sv
// Fairness counter for mem_port_arbiter (present only with MEM_PORT_ARB_FAIR_EN): after MAX_D_STREAK
// data grants taken while fetch was pending, fetch wins the next idle arbitration.
`ifdef MEM_PORT_ARB_FAIR_EN
module mem_port_arb_streak
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_idle,
  input  logic if_req,
  input  logic if_pend,
  input  logic grant_d,
  input  logic grant_i,
  output logic fetch_win
);

  localparam int CNT_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_STREAK);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (grant_i || (in_idle && !if_req)) begin
      cnt_q <= '0;
    end else if (grant_d && if_pend && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign fetch_win = if_pend && (cnt_q == CNT_MAX);

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch vs MEM-stage onto one handshaked memory port, one access in flight; grant to mem_en is
// one cycle, completion to ready pulse one cycle. MEM_PORT_ARB_FAIR_EN adds a bounded data-streak limit.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = LC3B_ADDR_W,
  parameter int DATA_W       = LC3B_WORD_W,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_instr,
  output logic              imem_r,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              dmem_r,
  output logic              mem_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_wmask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_e        state_q;
  logic              imem_r_q, dmem_r_q, mem_en_q, mem_we_q, stale_q;
  logic [1:0]        mem_wmask_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, if_instr_q, d_rdata_q;

  logic in_idle, if_pend, if_elig, d_elig, fetch_win, grant_d, grant_i;

  assign in_idle = (state_q == ARB_IDLE);
  assign if_pend = if_req && !imem_r_q;
  assign d_elig  = d_req && !dmem_r_q;

`ifdef MEM_PORT_ARB_FAIR_EN
  mem_port_arb_streak #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_streak (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_idle  (in_idle),
    .if_req   (if_req),
    .if_pend  (if_pend),
    .grant_d  (grant_d),
    .grant_i  (grant_i),
    .fetch_win(fetch_win)
  );
`else
  assign fetch_win = 1'b0;
`endif

  // A load/store still asserted through its own dmem_r is the next MEM access; it keeps priority over
  // fetch during that one-cycle gap so data can issue back to back.
  assign if_elig = if_pend && !(dmem_r_q && d_req && !fetch_win);
  assign grant_d = in_idle && d_elig && !fetch_win;
  assign grant_i = in_idle && if_elig && (!d_elig || fetch_win);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      imem_r_q    <= 1'b0;
      dmem_r_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wmask_q <= WMASK_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_instr_q  <= '0;
      d_rdata_q   <= '0;
      stale_q     <= 1'b0;
    end else begin
      imem_r_q <= 1'b0;
      dmem_r_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (grant_d) begin
            state_q     <= ARB_DACC;
            mem_en_q    <= 1'b1;
            mem_we_q    <= d_we;
            mem_wmask_q <= wmask_f(d_we, d_byte, d_addr[0]);
            mem_addr_q  <= {d_addr[ADDR_W-1:1], 1'b0};
            mem_wdata_q <= d_byte ? {d_wdata[7:0], d_wdata[7:0]} : d_wdata;
          end else if (grant_i) begin
            state_q     <= ARB_IFETCH;
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_wmask_q <= WMASK_NONE;
            mem_addr_q  <= {if_addr[ADDR_W-1:1], 1'b0};
            stale_q     <= 1'b0;
          end
        end
        ARB_IFETCH: begin
          if (!if_req) stale_q <= 1'b1;
          if (mem_ready) begin
            state_q  <= ARB_IDLE;
            mem_en_q <= 1'b0;
            // A redirected fetch still drains the memory but must not deliver a wrong-path word.
            if (!stale_q && if_req) begin
              if_instr_q <= mem_rdata;
              imem_r_q   <= 1'b1;
            end
          end
        end
        ARB_DACC: begin
          if (mem_ready) begin
            state_q     <= ARB_IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wmask_q <= WMASK_NONE;
            d_rdata_q   <= mem_rdata;
            dmem_r_q    <= 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign if_instr  = if_instr_q;
  assign imem_r    = imem_r_q;
  assign d_rdata   = d_rdata_q;
  assign dmem_r    = dmem_r_q;
  assign mem_stall = d_req && !dmem_r_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; inputs change and outputs are checked on the falling clock edge.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we, d_byte, mem_ready;
  logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [15:0] if_instr, d_rdata, mem_addr, mem_wdata;
  logic        imem_r, dmem_r, mem_stall, mem_en, mem_we;
  logic [1:0]  mem_wmask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_instr(if_instr), .imem_r(imem_r),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .dmem_r(dmem_r), .mem_stall(mem_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // A data request must stay up while its access is outstanding.
  always @(posedge clk) begin
    if (rst_n && dut.state_q == ARB_DACC)
      assert (d_req) else $error("d_req withdrawn during data access");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0; d_byte = 0; mem_ready = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    repeat (2) tick();
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    checks++; if (imem_r !== 1'b0 || dmem_r !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b%b want 00", imem_r, dmem_r); end
    checks++; if (mem_wmask !== 2'b00 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_we_mask: got %b/%b want 0/00", mem_we, mem_wmask); end
    checks++; if (if_instr !== 16'h0 || d_rdata !== 16'h0) begin errors++; $display("FAIL rst_data: got %h/%h want 0000/0000", if_instr, d_rdata); end
    rst_n = 1'b1; if_req = 1'b1; if_addr = 16'h3000;
    tick();
    checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h3000) begin errors++; $display("FAIL first_grant: got en=%b addr=%h want 1/3000", mem_en, mem_addr); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin errors++; $display("FAIL midfetch_rst: got en=%b addr=%h wd=%h want 0/0000/0000", mem_en, mem_addr, mem_wdata); end
    checks++; if (dut.state_q !== ARB_IDLE) begin errors++; $display("FAIL midfetch_state: got %0d want 0", dut.state_q); end
    rst_n = 1'b1;
    tick();
    checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h3000) begin errors++; $display("FAIL regrant: got en=%b addr=%h want 1/3000", mem_en, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 16'h1234;
    tick();
    checks++; if (imem_r !== 1'b1 || if_instr !== 16'h1234) begin errors++; $display("FAIL rst_fetch_done: got r=%b instr=%h want 1/1234", imem_r, if_instr); end
    if_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_fetch_read;
    if_req = 1'b1; if_addr = 16'h3002;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h3002 || imem_r !== 1'b0) begin errors++; $display("FAIL fetch_hold%0d: got en=%b addr=%h r=%b want 1/3002/0", c, mem_en, mem_addr, imem_r); end
    end
    mem_ready = 1'b1; mem_rdata = 16'habcd;
    tick();
    checks++; if (imem_r !== 1'b1 || if_instr !== 16'habcd || mem_en !== 1'b0) begin errors++; $display("FAIL fetch_done: got r=%b instr=%h en=%b want 1/abcd/0", imem_r, if_instr, mem_en); end
    mem_ready = 1'b0;
    tick();
    checks++; if (imem_r !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL fetch_no_dup: got r=%b en=%b want 0/0", imem_r, mem_en); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_contention;
    if_req = 1'b1; if_addr = 16'h3004;
    d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 16'h4000;
    #1;
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL stall_comb: got %b want 1", mem_stall); end
    tick();
    checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h4000 || mem_we !== 1'b0 || mem_wmask !== 2'b00) begin errors++; $display("FAIL contend_data_first: got en=%b addr=%h we=%b m=%b want 1/4000/0/00", mem_en, mem_addr, mem_we, mem_wmask); end
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", mem_stall); end
    mem_ready = 1'b1; mem_rdata = 16'h5555;
    tick();
    checks++; if (dmem_r !== 1'b1 || d_rdata !== 16'h5555 || mem_stall !== 1'b0 || imem_r !== 1'b0) begin errors++; $display("FAIL load_done: got r=%b d=%h stall=%b ir=%b want 1/5555/0/0", dmem_r, d_rdata, mem_stall, imem_r); end
    d_req = 1'b0; mem_ready = 1'b0;
    tick();
    checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h3004 || mem_we !== 1'b0) begin errors++; $display("FAIL contend_fetch_next: got en=%b addr=%h we=%b want 1/3004/0", mem_en, mem_addr, mem_we); end
    mem_ready = 1'b1; mem_rdata = 16'h7777;
    tick();
    checks++; if (imem_r !== 1'b1 || if_instr !== 16'h7777 || dmem_r !== 1'b0) begin errors++; $display("FAIL contend_fetch_done: got r=%b instr=%h dr=%b want 1/7777/0", imem_r, if_instr, dmem_r); end
    if_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_byte_store;
    d_req = 1'b1; d_we = 1'b1; d_byte = 1'b1; d_addr = 16'h4001; d_wdata = 16'h00ef;
    tick();
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h4000 || mem_wdata !== 16'hefef || mem_wmask !== 2'b10) begin errors++; $display("FAIL stb_hi: got en=%b we=%b a=%h wd=%h m=%b want 1/1/4000/efef/10", mem_en, mem_we, mem_addr, mem_wdata, mem_wmask); end
    mem_ready = 1'b1;
    tick();
    checks++; if (dmem_r !== 1'b1) begin errors++; $display("FAIL stb_hi_done: got %b want 1", dmem_r); end
    mem_ready = 1'b0; d_addr = 16'h4000; d_wdata = 16'h0012;
    tick();
    checks++; if (mem_en !== 1'b0 || dmem_r !== 1'b0) begin errors++; $display("FAIL stb_gap: got en=%b r=%b want 0/0", mem_en, dmem_r); end
    tick();
    checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h4000 || mem_wdata !== 16'h1212 || mem_wmask !== 2'b01) begin errors++; $display("FAIL stb_lo: got en=%b a=%h wd=%h m=%b want 1/4000/1212/01", mem_en, mem_addr, mem_wdata, mem_wmask); end
    mem_ready = 1'b1;
    tick();
    d_byte = 1'b0; d_addr = 16'h4006; d_wdata = 16'hbeef; mem_ready = 1'b0;
    repeat (2) tick();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h4006 || mem_wdata !== 16'hbeef || mem_wmask !== 2'b11) begin errors++; $display("FAIL stw: got we=%b a=%h wd=%h m=%b want 1/4006/beef/11", mem_we, mem_addr, mem_wdata, mem_wmask); end
    mem_ready = 1'b1;
    tick();
    checks++; if (dmem_r !== 1'b1 || mem_wmask !== 2'b00) begin errors++; $display("FAIL stw_done: got r=%b m=%b want 1/00", dmem_r, mem_wmask); end
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_redirect;
    if_req = 1'b1; if_addr = 16'h3008;
    tick();
    checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h3008) begin errors++; $display("FAIL redir_grant: got en=%b a=%h want 1/3008", mem_en, mem_addr); end
    if_req = 1'b0;
    tick();
    checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h3008) begin errors++; $display("FAIL redir_held: got en=%b a=%h want 1/3008", mem_en, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 16'h9999;
    tick();
    checks++; if (imem_r !== 1'b0 || if_instr !== 16'h7777 || mem_en !== 1'b0) begin errors++; $display("FAIL redir_suppress: got r=%b instr=%h en=%b want 0/7777/0", imem_r, if_instr, mem_en); end
    tick();
    checks++; if (imem_r !== 1'b0 || dmem_r !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL idle_ready_ignored: got ir=%b dr=%b en=%b want 0/0/0", imem_r, dmem_r, mem_en); end
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    logic exp_fetch [6];
    int   w;
`ifdef MEM_PORT_ARB_FAIR_EN
    exp_fetch = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    exp_fetch = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    if_req = 1'b1; if_addr = 16'h300a;
    d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 16'h4010;
    for (int k = 0; k < 6; k++) begin
      tick();
      w = 0;
      while (mem_en !== 1'b1 && w < 4) begin tick(); w++; end
      checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL b2b_grant_timeout%0d: got en=%b want 1", k, mem_en); end
      checks++; if (mem_addr !== (exp_fetch[k] ? 16'h300a : 16'h4010)) begin errors++; $display("FAIL b2b_order%0d: got a=%h want %h", k, mem_addr, exp_fetch[k] ? 16'h300a : 16'h4010); end
      mem_ready = 1'b1; mem_rdata = 16'h0100 + 16'(k);
      tick();
      checks++; if (imem_r !== exp_fetch[k] || dmem_r !== !exp_fetch[k]) begin errors++; $display("FAIL b2b_pulse%0d: got ir=%b dr=%b want %b/%b", k, imem_r, dmem_r, exp_fetch[k], !exp_fetch[k]); end
      mem_ready = 1'b0;
      if (k == 5) begin d_req = 1'b0; if_req = 1'b0; end
    end
    tick();
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL b2b_quiet: got en=%b want 0", mem_en); end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_contention();
    test_byte_store();
    test_redirect();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
